// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared memory constants and byte/word types for the
//               instruction and data RAMs.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/word_assemble_be.sv
`default_nettype none
// ============================================================================
// Module      : word_assemble_be
// Description : Packs four bytes into a 32-bit big-endian word. Byte 0 is
//               the lowest address and lands in the most-significant lane.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assemble_be
  import mem_pkg::*;
(
  input  byte_t i_byte0,
  input  byte_t i_byte1,
  input  byte_t i_byte2,
  input  byte_t i_byte3,
  output word_t o_word
);

  // Lowest-addressed byte goes to the top of the word.
  always_comb begin
    o_word = {i_byte0, i_byte1, i_byte2, i_byte3};
  end

endmodule : word_assemble_be
`default_nettype wire

// File: rtl/inst_ram_256x8.sv
`default_nettype none
// ============================================================================
// Module      : inst_ram_256x8
// Description : 256 x 8 byte-organised instruction memory. Combinational
//               big-endian 32-bit fetch at any byte address (wraps mod 256),
//               plus a synchronous byte-wide preload port. Reset forces the
//               fetched word to zero without disturbing the stored image.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_ram_256x8
  import mem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int BYTE_W     = 8,
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic              LoadEn,
  input  logic [7:0]        LoadAddr,
  input  logic [BYTE_W-1:0] LoadData,
  output logic [31:0]       DataOut
);

  localparam int IDX_W = $clog2(DEPTH);

  // Program image. The name is fixed so that a bench can preload it directly;
  // it is deliberately not cleared by reset so the image survives.
  logic [BYTE_W-1:0] Mem [0:DEPTH-1] = '{default: '0};

  logic [IDX_W-1:0]  rd_base;
  logic [IDX_W-1:0]  rd_idx      [WORD_BYTES];
  logic [BYTE_W-1:0] fetch_bytes [WORD_BYTES];
  word_t             assembled_word;

  // Upper PC bits select nothing in a 256-byte space.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^Address[ADDR_W-1:IDX_W];

  assign rd_base = Address[IDX_W-1:0];

  // Byte indices for the fetch; the narrow adder wraps past the top of memory.
  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_fetch_bytes
    assign rd_idx[i]      = rd_base + IDX_W'(i);
    assign fetch_bytes[i] = Mem[rd_idx[i]];
  end

  word_assemble_be u_word_assemble_be (
    .i_byte0 (fetch_bytes[0]),
    .i_byte1 (fetch_bytes[1]),
    .i_byte2 (fetch_bytes[2]),
    .i_byte3 (fetch_bytes[3]),
    .o_word  (assembled_word)
  );

  // Preload write; reset blocks it. A plain always keeps Mem writable from
  // outside the module for backdoor preload.
  always @(posedge clk) begin
    if (LoadEn && !Reset) begin
      Mem[LoadAddr] <= LoadData;
    end
  end

  // Fetched word, forced to zero while reset is held.
  always_comb begin
    DataOut = Reset ? 32'h0000_0000 : assembled_word;
  end

endmodule : inst_ram_256x8
`default_nettype wire

// File: tb/tb_inst_ram_256x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_ram_256x8
// Description : Self-checking bench for inst_ram_256x8: directed table,
//               hand-written load/reset sequences and randomized traffic
//               against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_ram_256x8;

  logic        clk      = 1'b0;
  logic        Reset    = 1'b1;
  logic [31:0] Address  = 32'h0;
  logic        LoadEn   = 1'b0;
  logic [7:0]  LoadAddr = 8'h0;
  logic [7:0]  LoadData = 8'h0;
  logic [31:0] DataOut;

  logic [7:0]  model [0:255];
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  inst_ram_256x8 dut (
    .clk      (clk),
    .Reset    (Reset),
    .Address  (Address),
    .LoadEn   (LoadEn),
    .LoadAddr (LoadAddr),
    .LoadData (LoadData),
    .DataOut  (DataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference fetch: four bytes starting at the low address byte, modulo 256.
  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr % 256);
    return {model[a], model[(a + 1) % 256], model[(a + 2) % 256], model[(a + 3) % 256]};
  endfunction

  task automatic bd(input int i, input logic [7:0] v);
    dut.Mem[i] = v;
    model[i]   = v;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    // Reset state and zero-initialised contents
    #1 check("reset_out", DataOut, 32'h0);
    Address = 32'h0000_0010;
    #1 check("reset_out_addr", DataOut, 32'h0);
    Reset = 1'b0;
    #1 check("zero_init", DataOut, 32'h0);

    // Backdoor word at 0, no clock needed
    bd(0, 8'hE3); bd(1, 8'hA0); bd(2, 8'h10); bd(3, 8'h05);
    Address = 32'h0;
    #1 check("bd_word0", DataOut, 32'hE3A0_1005);

    // 16 more words, sweep aligned addresses
    for (int i = 4; i < 68; i++) bd(i, 8'($urandom));
    for (int a = 0; a <= 64; a += 4) begin
      Address = 32'(a);
      #1 check($sformatf("sweep_%0d", a), DataOut, ref_word(Address));
    end

    // Upper address bits ignored
    Address = 32'h0000_0100;
    #1 check("hi_bits_100", DataOut, 32'hE3A0_1005);
    Address = 32'hFFFF_FF00;
    #1 check("hi_bits_ff00", DataOut, 32'hE3A0_1005);

    // Reset mid-read, asynchronous, contents retained
    Address = 32'h0;
    #1 check("pre_reset", DataOut, 32'hE3A0_1005);
    Reset = 1'b1;
    #1 check("async_reset", DataOut, 32'h0);
    Reset = 1'b0;
    #1 check("post_reset", DataOut, 32'hE3A0_1005);

    // Unaligned and wrap-around table
    bd(1, 8'h11); bd(2, 8'h22); bd(3, 8'h33); bd(4, 8'h44);
    bd(253, 8'hAA); bd(254, 8'hBB); bd(255, 8'hCC); bd(0, 8'hDD);
    vecs[0] = '{32'h0000_0001, 32'h1122_3344};
    vecs[1] = '{32'h0000_00FD, 32'hAABB_CCDD};
    vecs[2] = '{32'h0000_0000, 32'hDD11_2233};
    vecs[3] = '{32'h0000_0101, 32'h1122_3344};
    vecs[4] = '{32'hFFFF_FF01, 32'h1122_3344};
    vecs[5] = '{32'h0000_00FE, 32'hBBCC_DD11};
    vecs[6] = '{32'h1234_56FF, 32'hCCDD_1122};
    for (int i = 0; i < 7; i++) begin
      Address = vecs[i].addr;
      #1 check($sformatf("vec_%0d", i), DataOut, vecs[i].exp);
    end

    // Load port write visible right after the edge
    @(negedge clk);
    Address = 32'd8; LoadEn = 1'b1; LoadAddr = 8'd8; LoadData = 8'h7F;
    #1 check("load_before_edge", DataOut, ref_word(32'd8));
    @(posedge clk); model[8] = 8'h7F;
    #1 check("load_msb", {24'h0, DataOut[31:24]}, 32'h7F);
    check("load_word", DataOut, ref_word(32'd8));

    // Same write under reset is suppressed
    @(negedge clk);
    Reset = 1'b1; LoadData = 8'h55;
    @(posedge clk);
    #1 check("load_in_reset_out", DataOut, 32'h0);
    @(negedge clk);
    Reset = 1'b0; LoadEn = 1'b0;
    #1 check("load_in_reset_kept", {24'h0, DataOut[31:24]}, 32'h7F);

    // Address change together with a write to the fetched byte
    @(negedge clk);
    Address = 32'd9; LoadEn = 1'b1; LoadAddr = 8'd10; LoadData = 8'h3C;
    #1 check("same_cycle_old", DataOut, ref_word(32'd9));
    @(posedge clk); model[10] = 8'h3C;
    #1 check("same_cycle_new", DataOut, ref_word(32'd9));
    @(negedge clk); LoadEn = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      Address  = $urandom;
      Reset    = ($urandom_range(0, 15) == 0);
      LoadEn   = $urandom_range(0, 1) == 1;
      LoadAddr = ($urandom_range(0, 1) == 1) ? 8'(Address[7:0] + 8'($urandom_range(0, 3)))
                                            : 8'($urandom);
      LoadData = 8'($urandom);
      #1 check($sformatf("rnd_pre_%0d", n), DataOut, Reset ? 32'h0 : ref_word(Address));
      @(posedge clk);
      if (LoadEn && !Reset) model[LoadAddr] = LoadData;
      #1 check($sformatf("rnd_post_%0d", n), DataOut, Reset ? 32'h0 : ref_word(Address));
    end

    // Whole-image sweep after random loads, all byte addresses
    @(negedge clk);
    LoadEn = 1'b0; Reset = 1'b0;
    for (int a = 0; a < 256; a++) begin
      Address = 32'(a) | ($urandom & 32'hFFFF_FF00);
      #1 check($sformatf("final_%0d", a), DataOut, ref_word(Address));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_ram_256x8
`default_nettype wire
